// File: rtl/sd_spi_shift_xcvr.sv
// -----------------------------------------------------------------------------
// sd_spi_shift_xcvr
//
// Full-duplex SPI shift engine for the microSD path. It shifts an N-bit word
// out MSB-first on mosi and at the same time shifts miso into an N-bit receive
// word. All logic runs on the rising edge of sclkn (the inverted SPI clock),
// so mosi changes on the falling edge of SCK. Words can be chained without
// idle bits by holding start high into the final capture edge.
//
// Optional feature: define SD_SPI_CRC7_EN to add a running CRC7
// (x^7 + x^3 + 1) over every bit driven onto mosi, with crc_clr / crc7 ports.
//
// Parameters:
//   N          word width in bits (N >= 2)
//   CW         bit-counter width (2^CW > N)
//   IDLE_LEVEL mosi level while idle / after reset
//   FILL       bit shifted into the LSB of the transmit register
//
// Ports:
//   sclkn   in   clock, all logic on its rising edge
//   reset   in   asynchronous, active-high reset
//   enable  in   clock enable; low holds all state (done still self-clears)
//   start   in   transfer request, sampled on enabled edges
//   datase  in   [N-1:0] transmit word, captured on the load edge
//   miso    in   serial data from the card
//   crc_clr in   (SD_SPI_CRC7_EN only) synchronous CRC clear
//   mosi    out  registered serial data to the card
//   datain  out  [N-1:0] last complete received word
//   busy    out  transfer in progress
//   done    out  one-cycle pulse, datain updated
//   crc7    out  [6:0] (SD_SPI_CRC7_EN only) running CRC of mosi bits
//
// Handshake: a transfer starts on an enabled edge where start=1 while idle
// (the load edge); datase must be stable on that edge. done pulses for one
// cycle after the final capture edge. If start=1 on that final edge, the next
// word is loaded on the same edge and busy stays high.
// -----------------------------------------------------------------------------
module sd_spi_shift_xcvr #(
    parameter int   N          = 8,
    parameter int   CW         = 4,
    parameter logic IDLE_LEVEL = 1'b1,
    parameter logic FILL       = 1'b1
) (
    input  logic         sclkn,
    input  logic         reset,
    input  logic         enable,
    input  logic         start,
    input  logic [N-1:0] datase,
    input  logic         miso,
`ifdef SD_SPI_CRC7_EN
    input  logic         crc_clr,
    output logic [6:0]   crc7,
`endif
    output logic         mosi,
    output logic [N-1:0] datain,
    output logic         busy,
    output logic         done
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t         state, state_nx;
    logic [N-1:0]   tx, tx_nx;
    logic [N-1:0]   rx, rx_nx;
    logic [CW-1:0]  cnt, cnt_nx;
    logic           mosi_nx;
    logic [N-1:0]   datain_nx;
    logic           busy_nx;
    logic           done_nx;
    // High on edges where a fresh data bit is placed on mosi (load or shift).
    logic           drive_bit;

    // State register
    always_ff @(posedge sclkn or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            tx     <= '0;
            rx     <= '0;
            cnt    <= '0;
            mosi   <= IDLE_LEVEL;
            datain <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nx;
            tx     <= tx_nx;
            rx     <= rx_nx;
            cnt    <= cnt_nx;
            mosi   <= mosi_nx;
            datain <= datain_nx;
            busy   <= busy_nx;
            done   <= done_nx;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_nx  = state;
        tx_nx     = tx;
        rx_nx     = rx;
        cnt_nx    = cnt;
        mosi_nx   = mosi;
        datain_nx = datain;
        busy_nx   = busy;
        done_nx   = 1'b0;          // done self-clears even when enable is low
        drive_bit = 1'b0;

        if (enable) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mosi_nx   = datase[N-1];
                        tx_nx     = {datase[N-2:0], FILL};
                        cnt_nx    = CW'(N - 1);
                        busy_nx   = 1'b1;
                        state_nx  = SHIFT;
                        drive_bit = 1'b1;
                    end else begin
                        mosi_nx = IDLE_LEVEL;
                    end
                end
                SHIFT: begin
                    // miso is captured one edge after its mosi bit was driven
                    rx_nx = N'({rx, miso});
                    if (cnt != '0) begin
                        mosi_nx   = tx[N-1];
                        tx_nx     = {tx[N-2:0], FILL};
                        cnt_nx    = cnt - CW'(1);
                        drive_bit = 1'b1;
                    end else begin
                        datain_nx = N'({rx, miso});
                        done_nx   = 1'b1;
                        if (start) begin
                            // Back-to-back: load the next word on this same edge
                            mosi_nx   = datase[N-1];
                            tx_nx     = {datase[N-2:0], FILL};
                            cnt_nx    = CW'(N - 1);
                            drive_bit = 1'b1;
                        end else begin
                            mosi_nx  = IDLE_LEVEL;
                            busy_nx  = 1'b0;
                            state_nx = IDLE;
                        end
                    end
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

`ifdef SD_SPI_CRC7_EN
    // CRC7 over the bit stream on mosi; the new bit is the value about to be
    // registered onto mosi this edge.
    logic       crc_fb;
    logic [6:0] crc_upd;

    always_comb begin
        crc_fb  = crc7[6] ^ mosi_nx;
        crc_upd = {crc7[5:0], 1'b0} ^ (crc_fb ? 7'h09 : 7'h00);
    end

    always_ff @(posedge sclkn or posedge reset) begin
        if (reset) begin
            crc7 <= '0;
        end else if (enable) begin
            if (crc_clr) begin
                crc7 <= '0;
            end else if (drive_bit) begin
                crc7 <= crc_upd;
            end
        end
    end
`endif

endmodule
